// File: rtl/push_pull_fifo_out_mc.sv
// Multi-channel push-pull source: per-sink pessimistic credit counts, broadcast or unicast steering.
// Optional macro PUSH_PULL_STALL_STATS_EN adds the saturating stallCount output.
module push_pull_fifo_out_mc #(
    parameter int unsigned dataWidth      = 128,
    parameter int unsigned numInterfaces  = 4,
    parameter int unsigned extraFifoDepth = 0,
    parameter int unsigned noInputRegs    = 0,
    parameter int unsigned unicastMode    = 0,
    localparam int unsigned fifoDepth     = extraFifoDepth + ((noInputRegs != 0) ? 2 : 4),
    localparam int unsigned countBits     = $clog2(fifoDepth + 1),
    localparam int unsigned destBits      = (numInterfaces > 1) ? $clog2(numInterfaces) : 1
) (
    input  logic                               mclk,
    input  logic                               resetN,
    input  logic                               readRun_r,
    input  logic [numInterfaces-1:0]           enable_r,
    input  logic                               clearErrors_r,
    input  logic                               dataValidFromParent,
    input  logic [dataWidth-1:0]               dataFromParent,
    input  logic [destBits-1:0]                destFromParent,
    input  logic [numInterfaces-1:0]           reqFromNext,
    output logic                               dataXferToParent,
    output logic                               readyToParent,
    output logic [numInterfaces-1:0]           xferToNext,
    output logic [numInterfaces*dataWidth-1:0] dataToNext,
    output logic [numInterfaces-1:0]           counterError,
    output logic                               destError,
    output logic [numInterfaces*countBits-1:0] creditLevel
`ifdef PUSH_PULL_STALL_STATS_EN
    ,
    output logic [31:0]                        stallCount
`endif
);

    logic [numInterfaces-1:0] reqFromNext_r;
    logic [numInterfaces-1:0] room;
    logic [numInterfaces-1:0] target;
    logic [numInterfaces-1:0] push;
    logic [countBits-1:0]     count [numInterfaces];
    logic                     destOk;

    // Credit returns from disabled sinks are masked before they reach the counters.
    if (noInputRegs != 0) begin : gReqComb
        always_comb reqFromNext_r = enable_r & reqFromNext;
    end else begin : gReqReg
        always_ff @(posedge mclk or negedge resetN) begin
            if (!resetN) reqFromNext_r <= '0;
            else         reqFromNext_r <= enable_r & reqFromNext;
        end
    end

    always_comb begin
        room   = '0;
        target = '0;
        destOk = 1'b0;
        for (int unsigned i = 0; i < numInterfaces; i++) begin
            room[i] = reqFromNext_r[i] | (count[i] != countBits'(fifoDepth));
            destOk  = destOk | (enable_r[i] & (32'(destFromParent) == i));
            if (unicastMode != 0) target[i] = enable_r[i] & (32'(destFromParent) == i);
            else                  target[i] = enable_r[i];
        end
        // An out-of-range destination matches no sink, so it reads as disabled.
        if (unicastMode != 0)
            readyToParent = resetN & readRun_r & (|(target & room));
        else
            readyToParent = resetN & readRun_r & (|enable_r) & (&(room | ~enable_r));
        dataXferToParent = readyToParent & dataValidFromParent;
        push             = target & {numInterfaces{dataXferToParent}};
    end

    always_ff @(posedge mclk or negedge resetN) begin
        if (!resetN) begin
            xferToNext   <= '0;
            dataToNext   <= '0;
            counterError <= '0;
            destError    <= 1'b0;
            for (int unsigned i = 0; i < numInterfaces; i++) count[i] <= '0;
        end else begin
            xferToNext <= push;
            for (int unsigned i = 0; i < numInterfaces; i++) begin
                if (push[i]) dataToNext[i*dataWidth +: dataWidth] <= dataFromParent;

                if (!readRun_r || !enable_r[i])
                    count[i] <= '0;
                else if (push[i] && !reqFromNext_r[i])
                    count[i] <= count[i] + countBits'(1);
                else if (!push[i] && reqFromNext_r[i] && (count[i] != '0))
                    count[i] <= count[i] - countBits'(1);

                counterError[i] <= (counterError[i] & ~clearErrors_r)
                                 | (readRun_r & (((count[i] == '0) & reqFromNext_r[i])
                                               | (~enable_r[i] & reqFromNext[i])));
            end
            destError <= (destError & ~clearErrors_r)
                       | ((unicastMode != 0) & readRun_r & dataValidFromParent & ~destOk);
        end
    end

    always_comb begin
        creditLevel = '0;
        for (int unsigned i = 0; i < numInterfaces; i++)
            creditLevel[i*countBits +: countBits] = count[i];
    end

`ifdef PUSH_PULL_STALL_STATS_EN
    always_ff @(posedge mclk or negedge resetN) begin
        if (!resetN)
            stallCount <= '0;
        else if (clearErrors_r)
            stallCount <= '0;
        else if (dataValidFromParent && readRun_r && !readyToParent && (stallCount != '1))
            stallCount <= stallCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_push_pull_fifo_out_mc.sv
// Directed bench for push_pull_fifo_out_mc: one broadcast instance (4 sinks) and one unicast instance (3 sinks).
module tb_push_pull_fifo_out_mc;

    localparam int unsigned DW = 32;

    logic        mclk = 1'b0;
    logic        resetN, readRun, clearErrors;
    logic [31:0] pData;

    logic [3:0]   bEnable, bReq, bXfer, bErr;
    logic         bValid, bReady, bXferP, bDestErr;
    logic [1:0]   bDest;
    logic [127:0] bData;
    logic [11:0]  bCredit;

    logic [2:0]  uEnable, uReq, uXfer, uErr;
    logic        uValid, uReady, uXferP, uDestErr;
    logic [1:0]  uDest;
    logic [95:0] uData;
    logic [8:0]  uCredit;
`ifdef PUSH_PULL_STALL_STATS_EN
    logic [31:0] bStall, uStall;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } exp_t;
    exp_t bQ[$];
    exp_t uQ[$];

    push_pull_fifo_out_mc #(
        .dataWidth(DW), .numInterfaces(4), .extraFifoDepth(0), .noInputRegs(0), .unicastMode(0)
    ) uBcast (
        .mclk(mclk), .resetN(resetN), .readRun_r(readRun), .enable_r(bEnable),
        .clearErrors_r(clearErrors), .dataValidFromParent(bValid), .dataFromParent(pData),
        .destFromParent(bDest), .reqFromNext(bReq), .dataXferToParent(bXferP),
        .readyToParent(bReady), .xferToNext(bXfer), .dataToNext(bData),
        .counterError(bErr), .destError(bDestErr), .creditLevel(bCredit)
`ifdef PUSH_PULL_STALL_STATS_EN
        , .stallCount(bStall)
`endif
    );

    push_pull_fifo_out_mc #(
        .dataWidth(DW), .numInterfaces(3), .extraFifoDepth(0), .noInputRegs(0), .unicastMode(1)
    ) uUcast (
        .mclk(mclk), .resetN(resetN), .readRun_r(readRun), .enable_r(uEnable),
        .clearErrors_r(clearErrors), .dataValidFromParent(uValid), .dataFromParent(pData),
        .destFromParent(uDest), .reqFromNext(uReq), .dataXferToParent(uXferP),
        .readyToParent(uReady), .xferToNext(uXfer), .dataToNext(uData),
        .counterError(uErr), .destError(uDestErr), .creditLevel(uCredit)
`ifdef PUSH_PULL_STALL_STATS_EN
        , .stallCount(uStall)
`endif
    );

    always #5 mclk = ~mclk;

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; every cycle either retires one scoreboard entry or expects no push.
    task automatic tick();
        exp_t e;
        @(posedge mclk);
        #1;
        if (bQ.size() != 0) begin
            e = bQ.pop_front();
            chk("b_xferToNext", 64'(bXfer), 64'(e.mask));
            for (int i = 0; i < 4; i++)
                if (e.mask[i]) chk("b_dataToNext", 64'(bData[i*DW +: DW]), 64'(e.data));
        end else begin
            chk("b_xferToNext_idle", 64'(bXfer), 64'd0);
        end
        if (uQ.size() != 0) begin
            e = uQ.pop_front();
            chk("u_xferToNext", 64'(uXfer), 64'(e.mask));
            for (int i = 0; i < 3; i++)
                if (e.mask[i]) chk("u_dataToNext", 64'(uData[i*DW +: DW]), 64'(e.data));
        end else begin
            chk("u_xferToNext_idle", 64'(uXfer), 64'd0);
        end
    endtask

    task automatic offerB(input logic [31:0] d, input logic expAcc, input string tag);
        pData  = d;
        bValid = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(bReady), 64'(expAcc));
        chk({tag, "_xfer"}, 64'(bXferP), 64'(expAcc));
        if (expAcc) bQ.push_back({bEnable, d});
        tick();
    endtask

    task automatic offerU(input logic [31:0] d, input logic [1:0] dest, input logic expAcc,
                          input logic [3:0] mask, input string tag);
        pData  = d;
        uDest  = dest;
        uValid = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(uReady), 64'(expAcc));
        chk({tag, "_xfer"}, 64'(uXferP), 64'(expAcc));
        if (expAcc) uQ.push_back({mask, d});
        tick();
    endtask

    initial begin
        resetN = 1'b0; readRun = 1'b1; clearErrors = 1'b0; pData = '0;
        bEnable = 4'hF; bReq = '0; bValid = 1'b0; bDest = '0;
        uEnable = 3'h7; uReq = '0; uValid = 1'b0; uDest = '0;

        #3;
        chk("rst_b_ready", 64'(bReady), 64'd0);
        chk("rst_u_ready", 64'(uReady), 64'd0);
        chk("rst_b_xfer", 64'(bXfer), 64'd0);
        chk("rst_b_data", 64'(bData[63:0]), 64'd0);
        chk("rst_b_credit", 64'(bCredit), 64'd0);
        chk("rst_b_err", 64'(bErr), 64'd0);
        chk("rst_u_destErr", 64'(uDestErr), 64'd0);

        @(posedge mclk);
        #1;
        resetN = 1'b1;
        #1;
        chk("idle_b_ready", 64'(bReady), 64'd1);
        chk("idle_u_ready", 64'(uReady), 64'd1);

        // Broadcast fill: exactly four words fit, then ready drops.
        for (int k = 0; k < 6; k++) offerB(32'hA000 + 32'(k), (k < 4), "b_fill");
        bValid = 1'b0;
        chk("b_full_credit", 64'(bCredit), 64'h924);
        chk("b_full_ready", 64'(bReady), 64'd0);
`ifdef PUSH_PULL_STALL_STATS_EN
        chk("b_stall", 64'(bStall), 64'd2);
`endif

        // Only sinks 0 and 2 enabled.
        bEnable = 4'b0101;
        tick();
        chk("b_partial_credit", 64'(bCredit), 64'h104);
        chk("b_partial_ready", 64'(bReady), 64'd0);
        bReq = 4'b0001;
        tick();
        bReq = 4'b0000;
        #1;
        chk("b_pop_ready", 64'(bReady), 64'd0);
        tick();
        chk("b_pop_credit", 64'(bCredit), 64'h103);
        chk("b_pop_ready_s2full", 64'(bReady), 64'd0);
        bReq = 4'b0100;
        tick();
        bReq = 4'b0000;
        offerB(32'hA100, 1'b1, "b_pushpop");
        bValid = 1'b0;
        chk("b_pushpop_credit", 64'(bCredit), 64'h104);
        chk("b_pushpop_ready", 64'(bReady), 64'd0);

        // Credit return on an empty sink.
        bEnable = 4'hF;
        tick();
        bReq = 4'b1000;
        tick();
        chk("b_err_pre", 64'(bErr), 64'd0);
        bReq = 4'b0000;
        tick();
        chk("b_err_set", 64'(bErr), 64'h8);
        chk("b_err_credit", 64'(bCredit), 64'h104);
        tick();
        chk("b_err_sticky", 64'(bErr), 64'h8);
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        chk("b_err_clr", 64'(bErr), 64'd0);

        // Unicast: fill sink 2, then steer to empty sink 1.
        for (int k = 0; k < 5; k++) offerU(32'hB000 + 32'(k), 2'd2, (k < 4), 4'b0100, "u_fill");
        offerU(32'hB100, 2'd1, 1'b1, 4'b0010, "u_switch");
        uValid = 1'b0;
        chk("u_credit", 64'(uCredit), 64'h108);

        // Out-of-range destination.
        uDest  = 2'd3;
        uValid = 1'b1;
        #1;
        chk("u_bad_ready", 64'(uReady), 64'd0);
        chk("u_bad_xfer", 64'(uXferP), 64'd0);
        tick();
        chk("u_destErr_set", 64'(uDestErr), 64'd1);
        uValid = 1'b0;
        tick();
        chk("u_destErr_sticky", 64'(uDestErr), 64'd1);
        clearErrors = 1'b1;
        tick();
        clearErrors = 1'b0;
        chk("u_destErr_clr", 64'(uDestErr), 64'd0);

        // readRun low clears counts; ready follows readRun combinationally.
        readRun = 1'b0;
        tick();
        chk("run_b_credit", 64'(bCredit), 64'd0);
        chk("run_u_credit", 64'(uCredit), 64'd0);
        readRun = 1'b1;
        #1;
        chk("run_b_ready_hi", 64'(bReady), 64'd1);
        readRun = 1'b0;
        #1;
        chk("run_b_ready_drop", 64'(bReady), 64'd0);
        readRun = 1'b1;

        // Asynchronous reset in the middle of a burst.
        offerB(32'hC000, 1'b1, "b_burst");
        offerB(32'hC001, 1'b1, "b_burst");
        resetN = 1'b0;
        #1;
        chk("arst_b_xfer", 64'(bXfer), 64'd0);
        chk("arst_b_data", 64'(bData[63:0]), 64'd0);
        chk("arst_b_credit", 64'(bCredit), 64'd0);
        chk("arst_b_ready", 64'(bReady), 64'd0);
        chk("arst_b_dataXfer", 64'(bXferP), 64'd0);
        bValid = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        offerB(32'hC100, 1'b1, "b_post_rst");
        bValid = 1'b0;
        chk("post_rst_credit", 64'(bCredit), 64'h249);

        chk("b_queue_drained", 64'(bQ.size()), 64'd0);
        chk("u_queue_drained", 64'(uQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
